// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolver
//  Description : EX-stage branch resolution. Compares the prediction bundle
//                that travelled down the pipe with the real outcome. It raises
//                a one-cycle front-end redirect and queues one predictor update
//                packet per resolved instruction. The packets drain one per
//                cycle into the predictor update port.
//  Ports       : clk, rstn (async, active low)
//                ex_valid/ex_ready           - resolved instruction handshake
//                pc_ex, kind_real, taken_real, target_real - real outcome
//                pdc_npc, pdc_kind, pdc_taken, pdc_choice, pdc_pdch, pdc_bh
//                                            - prediction bundle
//                redirect, redirect_pc       - refetch request (1-cycle pulse)
//                upd_en/upd_ready, upd_*     - update packet, head of FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver #(
  parameter int ADDR_WIDTH = 30,
  parameter int bh_width   = 14,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [ADDR_WIDTH-1:0] pc_ex,
  input  logic [2:0]            kind_real,
  input  logic                  taken_real,
  input  logic [ADDR_WIDTH-1:0] target_real,
  input  logic [ADDR_WIDTH-1:0] pdc_npc,
  input  logic [2:0]            pdc_kind,
  input  logic                  pdc_taken,
  input  logic [1:0]            pdc_choice,
  input  logic [7:0]            pdc_pdch,
  input  logic [bh_width-1:0]   pdc_bh,
  output logic                  redirect,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  upd_en,
  input  logic                  upd_ready,
  output logic [ADDR_WIDTH-1:0] upd_pc,
  output logic [ADDR_WIDTH-1:0] upd_npc,
  output logic [ADDR_WIDTH-1:0] upd_ret_pc,
  output logic [2:0]            upd_kind,
  output logic                  upd_taken,
  output logic [bh_width-1:0]   upd_bh,
  output logic [2:0]            upd_mis,
  output logic [1:0]            upd_choice_real,
  output logic [1:0]            upd_choice_pdc,
  output logic [7:0]            upd_pdch
);

  localparam int                    c_PTR_W    = $clog2(DEPTH);
  localparam int                    c_PKT_W    = 3*ADDR_WIDTH + 3 + 1 + bh_width + 3 + 2 + 2 + 8;
  localparam logic [2:0]            c_KIND_NJ  = 3'd0;
  localparam logic [2:0]            c_KIND_RET = 3'd4;
  localparam logic [ADDR_WIDTH-1:0] c_PC_ONE   = ADDR_WIDTH'(1);
  localparam logic [c_PTR_W:0]      c_PTR_ONE  = (c_PTR_W+1)'(1);

  logic [ADDR_WIDTH-1:0] w_ret_pc;
  logic [ADDR_WIDTH-1:0] w_real_npc;
  logic [2:0]            w_mis;
  logic [1:0]            w_choice_real;
  logic                  w_g_ok;
  logic                  w_b_ok;
  logic                  w_shadow;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [c_PKT_W-1:0]    w_pkt_in;

  logic [c_PKT_W-1:0]    r_mem [DEPTH];
  logic [c_PTR_W:0]      r_wr_ptr;
  logic [c_PTR_W:0]      r_rd_ptr;
  logic                  r_redirect;
  logic [ADDR_WIDTH-1:0] r_redirect_pc;

  // Real outcome and misprediction classification. pc+1 wraps in ADDR_WIDTH.
  assign w_ret_pc   = pc_ex + c_PC_ONE;
  assign w_real_npc = taken_real ? target_real : w_ret_pc;

  assign w_mis[2] = (pdc_npc != w_real_npc);
  assign w_mis[1] = (pdc_kind != kind_real);
  assign w_mis[0] = (kind_real != c_KIND_NJ) && (pdc_taken != taken_real);

  // Chooser training: steer toward the sub-predictor that alone was right.
  // RET flips the ras/btb choice only when the target was wrong.
  assign w_g_ok = (pdc_pdch[7] == taken_real);
  assign w_b_ok = (pdc_pdch[5] == taken_real);

  always_comb begin
    w_choice_real[0] = pdc_choice[0];
    if (w_g_ok && !w_b_ok) begin
      w_choice_real[0] = 1'b1;
    end else if (w_b_ok && !w_g_ok) begin
      w_choice_real[0] = 1'b0;
    end
    w_choice_real[1] = (kind_real == c_KIND_RET) ? (pdc_choice[1] ^ w_mis[2]) : pdc_choice[1];
  end

  // The shadow cycle coincides exactly with the redirect pulse: the
  // instruction in EX during that cycle was fetched down the wrong path.
  assign w_shadow = r_redirect;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

  // A full FIFO still accepts when the head drains on the same edge.
  assign ex_ready = !w_full || upd_ready;
  assign w_accept = ex_valid && ex_ready && !w_shadow;
  assign w_pop    = !w_empty && upd_ready;

  assign w_pkt_in = {pc_ex, w_real_npc, w_ret_pc, kind_real, taken_real, pdc_bh,
                     w_mis, w_choice_real, pdc_choice, pdc_pdch};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_pkt_in;
        r_wr_ptr                     <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Redirect is issued straight from accept, independent of the update drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= w_accept && w_mis[2];
      if (w_accept && w_mis[2]) begin
        r_redirect_pc <= w_real_npc;
      end
    end
  end

  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;

  // Head entry is read straight out of storage flops, so the packet stays
  // stable while the predictor back-pressures; storage resets to zero.
  assign upd_en = !w_empty;
  assign {upd_pc, upd_npc, upd_ret_pc, upd_kind, upd_taken, upd_bh,
          upd_mis, upd_choice_real, upd_choice_pdc, upd_pdch} = r_mem[r_rd_ptr[c_PTR_W-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolver
//  Description : Self-checking bench for branch_resolver. A queue-based
//                reference model tracks expected packets and redirects; a
//                compare process checks every cycle, and directed scenarios
//                pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;

  localparam int AW    = 30;
  localparam int BHW   = 14;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           ex_valid;
  logic           ex_ready;
  logic [AW-1:0]  pc_ex;
  logic [2:0]     kind_real;
  logic           taken_real;
  logic [AW-1:0]  target_real;
  logic [AW-1:0]  pdc_npc;
  logic [2:0]     pdc_kind;
  logic           pdc_taken;
  logic [1:0]     pdc_choice;
  logic [7:0]     pdc_pdch;
  logic [BHW-1:0] pdc_bh;
  logic           redirect;
  logic [AW-1:0]  redirect_pc;
  logic           upd_en;
  logic           upd_ready;
  logic [AW-1:0]  upd_pc, upd_npc, upd_ret_pc;
  logic [2:0]     upd_kind;
  logic           upd_taken;
  logic [BHW-1:0] upd_bh;
  logic [2:0]     upd_mis;
  logic [1:0]     upd_choice_real, upd_choice_pdc;
  logic [7:0]     upd_pdch;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolver #(.ADDR_WIDTH(AW), .bh_width(BHW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .pc_ex(pc_ex), .kind_real(kind_real), .taken_real(taken_real),
    .target_real(target_real), .pdc_npc(pdc_npc), .pdc_kind(pdc_kind),
    .pdc_taken(pdc_taken), .pdc_choice(pdc_choice), .pdc_pdch(pdc_pdch),
    .pdc_bh(pdc_bh), .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_npc(upd_npc),
    .upd_ret_pc(upd_ret_pc), .upd_kind(upd_kind), .upd_taken(upd_taken),
    .upd_bh(upd_bh), .upd_mis(upd_mis), .upd_choice_real(upd_choice_real),
    .upd_choice_pdc(upd_choice_pdc), .upd_pdch(upd_pdch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]  pc, npc, ret_pc;
    logic [2:0]     kind;
    logic           taken;
    logic [BHW-1:0] bh;
    logic [2:0]     mis;
    logic [1:0]     ch_real, ch_pdc;
    logic [7:0]     pdch;
  } pkt_t;

  pkt_t          mq[$];
  logic          m_redirect;
  logic [AW-1:0] m_redirect_pc;

  logic [2:0] kinds [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected packet from the resolution rules applied to the current inputs.
  function automatic pkt_t model_pkt();
    pkt_t p;
    logic g_right, b_right;
    p.pc     = pc_ex;
    p.ret_pc = pc_ex + AW'(1);
    p.npc    = taken_real ? target_real : p.ret_pc;
    p.kind   = kind_real;
    p.taken  = taken_real;
    p.bh     = pdc_bh;
    p.mis    = {pdc_npc != p.npc, pdc_kind != kind_real,
                (kind_real != 3'd0) && (pdc_taken != taken_real)};
    g_right  = (pdc_pdch[7] == taken_real);
    b_right  = (pdc_pdch[5] == taken_real);
    case ({g_right, b_right})
      2'b10:   p.ch_real[0] = 1'b1;
      2'b01:   p.ch_real[0] = 1'b0;
      default: p.ch_real[0] = pdc_choice[0];
    endcase
    if (kind_real == 3'd4 && p.mis[2]) p.ch_real[1] = ~pdc_choice[1];
    else                               p.ch_real[1] = pdc_choice[1];
    p.ch_pdc = pdc_choice;
    p.pdch   = pdc_pdch;
    return p;
  endfunction

  always @(posedge clk or negedge rstn) begin : model
    bit   ready, acc;
    pkt_t p;
    if (!rstn) begin
      mq.delete();
      m_redirect    = 1'b0;
      m_redirect_pc = '0;
    end else begin
      ready = (mq.size() < DEPTH) || upd_ready;
      acc   = ex_valid && ready && !m_redirect;
      p     = model_pkt();
      if (mq.size() != 0 && upd_ready) void'(mq.pop_front());
      if (acc) mq.push_back(p);
      m_redirect = acc && p.mis[2];
      if (m_redirect) m_redirect_pc = p.npc;
    end
  end

  always @(negedge clk) begin : compare
    pkt_t h;
    if (!rstn) begin
      chk("rst_upd_en", upd_en, 0);
      chk("rst_redirect", redirect, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_upd_pc", upd_pc, 0);
    end
    chk("ex_ready", ex_ready, (mq.size() < DEPTH) || upd_ready);
    chk("redirect", redirect, m_redirect);
    if (m_redirect) chk("redirect_pc", redirect_pc, m_redirect_pc);
    chk("upd_en", upd_en, mq.size() != 0);
    if (upd_en && mq.size() != 0) begin
      h = mq[0];
      chk("upd_pc", upd_pc, h.pc);
      chk("upd_npc", upd_npc, h.npc);
      chk("upd_ret_pc", upd_ret_pc, h.ret_pc);
      chk("upd_kind", upd_kind, h.kind);
      chk("upd_taken", upd_taken, h.taken);
      chk("upd_bh", upd_bh, h.bh);
      chk("upd_mis", upd_mis, h.mis);
      chk("upd_choice_real", upd_choice_real, h.ch_real);
      chk("upd_choice_pdc", upd_choice_pdc, h.ch_pdc);
      chk("upd_pdch", upd_pdch, h.pdch);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
  endtask

  task automatic present(input logic [AW-1:0] pc, input logic [2:0] k, input logic t,
                         input logic [AW-1:0] tgt, input logic [AW-1:0] pnpc,
                         input logic [2:0] pk, input logic pt, input logic [1:0] pch,
                         input logic [7:0] pd, input logic [BHW-1:0] bh);
    ex_valid = 1'b1; pc_ex = pc; kind_real = k; taken_real = t; target_real = tgt;
    pdc_npc = pnpc; pdc_kind = pk; pdc_taken = pt; pdc_choice = pch; pdc_pdch = pd; pdc_bh = bh;
  endtask

  task automatic present_ok(input logic [AW-1:0] pc);
    present(pc, 3'd0, 1'b0, '0, pc + AW'(1), 3'd0, 1'b0, 2'b00, 8'h00, pc[BHW-1:0]);
  endtask

  task automatic rand_instr();
    logic [AW-1:0] npc;
    ex_valid    = ($urandom_range(0, 9) < 7);
    pc_ex       = ($urandom_range(0, 15) == 0) ? {AW{1'b1}} : AW'($urandom);
    kind_real   = kinds[$urandom_range(0, 5)];
    taken_real  = 1'($urandom);
    target_real = AW'($urandom);
    npc         = taken_real ? target_real : pc_ex + AW'(1);
    pdc_npc     = ($urandom_range(0, 2) != 0) ? npc : AW'($urandom);
    pdc_kind    = ($urandom_range(0, 3) != 0) ? kind_real : 3'($urandom);
    pdc_taken   = ($urandom_range(0, 3) != 0) ? taken_real : ~taken_real;
    pdc_choice  = 2'($urandom);
    pdc_pdch    = 8'($urandom);
    pdc_bh      = BHW'($urandom);
    upd_ready   = ($urandom_range(0, 9) < 6);
  endtask

  initial begin
    int pulses;
    rstn = 1'b0; upd_ready = 1'b0;
    present_ok('0); idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_upd_en", upd_en, 0);
    chk("reset_redirect", redirect, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_upd_mis", upd_mis, 0);
    chk("reset_ex_ready", ex_ready, 1);
    step(); rstn = 1'b1;

    // Reset mid-stream with three packets queued and a redirect pending.
    step(); upd_ready = 1'b0; present_ok(30'h10);
    step(); present_ok(30'h11);
    step(); present(30'h12, 3'd1, 1'b1, 30'h80, 30'h13, 3'd1, 1'b0, 2'b00, 8'h00, '0);
    step(); idle(); rstn = 1'b0;
    @(negedge clk);
    chk("t1_upd_en", upd_en, 0);
    chk("t1_redirect", redirect, 0);
    step(); rstn = 1'b1; upd_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t1_no_pkt_after_reset", upd_en, 0);
      step();
    end

    // Taken DIRECT predicted not taken; the following instruction is wrong-path.
    present(30'h100, 3'd1, 1'b1, 30'h200, 30'h101, 3'd1, 1'b0, 2'b00, 8'h00, 14'h1);
    step(); present_ok(30'h120);
    @(negedge clk);
    chk("t2_redirect", redirect, 1);
    chk("t2_redirect_pc", redirect_pc, 30'h200);
    chk("t2_upd_en", upd_en, 1);
    chk("t2_upd_pc", upd_pc, 30'h100);
    chk("t2_upd_mis", upd_mis, 3'b101);
    chk("t2_upd_npc", upd_npc, 30'h200);
    chk("t2_upd_ret_pc", upd_ret_pc, 30'h101);
    step(); idle();
    @(negedge clk);
    chk("t2_redirect_off", redirect, 0);
    chk("t2_shadow_dropped", upd_en, 0);

    // Correctly predicted RET at the top of the address space.
    step(); present(30'h3FFFFFFF, 3'd4, 1'b1, 30'h0, 30'h0, 3'd4, 1'b1, 2'b10, 8'b1010_0000, 14'h2A);
    step(); idle();
    @(negedge clk);
    chk("t3_redirect", redirect, 0);
    chk("t3_upd_mis", upd_mis, 3'b000);
    chk("t3_upd_ret_pc", upd_ret_pc, 30'h0);
    chk("t3_choice_real", upd_choice_real, 2'b10);

    // g wrong, b right -> chooser trained toward b.
    step(); present(30'h40, 3'd1, 1'b0, 30'h99, 30'h41, 3'd1, 1'b0, 2'b01, 8'b1000_0000, '0);
    step(); idle();
    @(negedge clk);
    chk("t4_choice_real", upd_choice_real, 2'b00);
    chk("t4_upd_mis", upd_mis, 3'b000);
    chk("t4_choice_pdc", upd_choice_pdc, 2'b01);

    // Back-pressure: fill, stall the fifth, then same-edge push and pop.
    step(); upd_ready = 1'b0; present_ok(30'h500);
    for (int i = 1; i <= 4; i++) begin
      step(); present_ok(30'h500 + AW'(i));
    end
    @(negedge clk);
    chk("t5_ex_ready_full", ex_ready, 0);
    chk("t5_head", upd_pc, 30'h500);
    step(); upd_ready = 1'b1;
    @(negedge clk);
    chk("t5_ex_ready_pop", ex_ready, 1);
    step(); idle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t5_order", upd_pc, 30'h500 + AW'(k));
      step();
    end
    @(negedge clk);
    chk("t5_drained", upd_en, 0);

    // Two back-to-back mispredicts: only the first takes effect.
    pulses = 0;
    step(); present(30'h600, 3'd1, 1'b1, 30'h700, 30'h601, 3'd1, 1'b0, 2'b00, 8'h00, '0);
    step(); present(30'h610, 3'd1, 1'b1, 30'h800, 30'h611, 3'd1, 1'b0, 2'b00, 8'h00, '0);
    @(negedge clk);
    if (redirect) pulses++;
    chk("t6_redirect_pc", redirect_pc, 30'h700);
    step(); idle();
    @(negedge clk);
    if (redirect) pulses++;
    chk("t6_second_dropped", upd_en, 0);
    repeat (3) begin
      step();
      @(negedge clk);
      if (redirect) pulses++;
    end
    chk("t6_pulses", pulses, 1);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) rstn = 1'b0;
      if (i == 1503) rstn = 1'b1;
      rand_instr();
    end
    step(); idle(); upd_ready = 1'b1;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
